// File: rtl/cmd_feeder_if.sv
// Handshake bundle between the host byte source, cmd_feeder and the CCU command input.
// The master side drives host bytes and ccu_ready; the slave side is cmd_feeder.
interface cmd_feeder_if;
  logic [7:0] host_data;
  logic       host_valid;
  logic       host_ready;
  logic [7:0] cmd;
  logic       cmd_valid;
  logic       ccu_ready;

  modport master (output host_data, host_valid, ccu_ready,
                  input  host_ready, cmd, cmd_valid);
  modport slave  (input  host_data, host_valid, ccu_ready,
                  output host_ready, cmd, cmd_valid);
endinterface

// File: rtl/cmd_feeder.sv
// Command feeder: FIFO-buffers host bytes, parses P/L commands and paces them onto cmd with NOP fill.
// Optional macro CMD_FEEDER_ERRCNT_EN enables the saturating unknown-opcode counter on err_cnt.
module cmd_feeder #(
  parameter int         DEPTH    = 16,
  parameter logic [7:0] NOP_BYTE = 8'h00,
  parameter int         LFILL    = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cmd_feeder_if.slave            bus,
  output logic                   busy,
  output logic                   err,
  output logic [7:0]             err_cnt,
  output logic [$clog2(DEPTH):0] fifo_level
);
  localparam int         AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [7:0] OP_P     = 8'd80;
  localparam logic [7:0] OP_L     = 8'd76;
  localparam logic [2:0] FILL_CNT = 3'(LFILL);

  typedef enum logic [2:0] {IDLE, P_OPS, L_OPS1, L_FILL, L_OPS2, L_WAIT} state_e;

  state_e         state_q, state_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [7:0]     cmd_q, cmd_d;
  logic           cmd_valid_q, cmd_valid_d;
  logic           err_q, err_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]    level_q, level_d;
  logic [7:0]     mem_q [DEPTH];
  logic           push_s, pop_s, empty_s, host_ready_s, out_free_s;
  logic [7:0]     head_s;
`ifdef CMD_FEEDER_ERRCNT_EN
  logic [7:0]     err_cnt_q, err_cnt_d;
`endif

  // host_ready is forced low while reset is asserted so nothing is admitted during a flush
  assign host_ready_s = rst_n & (level_q != FULL_LVL);
  assign push_s       = bus.host_valid & host_ready_s;
  assign empty_s      = (level_q == {(AW+1){1'b0}});
  assign head_s       = mem_q[rd_ptr_q];
  assign out_free_s   = ~cmd_valid_q | bus.ccu_ready;

  assign bus.host_ready = host_ready_s;
  assign bus.cmd        = cmd_q;
  assign bus.cmd_valid  = cmd_valid_q;
  assign busy           = (state_q != IDLE) | ~empty_s;
  assign err            = err_q;
  assign fifo_level     = level_q;

  // FIFO pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  // Parser FSM: decides what loads into the cmd register whenever it is free
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    pop_s   = 1'b0;
`ifdef CMD_FEEDER_ERRCNT_EN
    err_cnt_d = err_cnt_q;
`endif
    if (out_free_s) begin
      cmd_d       = NOP_BYTE;
      cmd_valid_d = 1'b0;
    end else begin
      cmd_d       = cmd_q;
      cmd_valid_d = cmd_valid_q;
    end
    case (state_q)
      IDLE: begin
        if (bus.ccu_ready && !empty_s) begin
          pop_s = 1'b1;
          if (head_s == OP_P) begin
            cmd_d = head_s; cmd_valid_d = 1'b1; state_d = P_OPS; cnt_d = 3'd3;
          end else if (head_s == OP_L) begin
            cmd_d = head_s; cmd_valid_d = 1'b1; state_d = L_OPS1; cnt_d = 3'd5;
          end else begin
            err_d = 1'b1;
`ifdef CMD_FEEDER_ERRCNT_EN
            err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
`endif
          end
        end else begin
          pop_s = 1'b0;
        end
      end
      P_OPS, L_OPS1, L_OPS2: begin
        // Operands go straight through; they are never decoded as opcodes
        if (out_free_s && !empty_s) begin
          pop_s       = 1'b1;
          cmd_d       = head_s;
          cmd_valid_d = 1'b1;
          cnt_d       = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            case (state_q)
              P_OPS:   state_d = IDLE;
              L_OPS1:  begin state_d = L_FILL; cnt_d = FILL_CNT; end
              default: state_d = L_WAIT;
            endcase
          end else begin
            state_d = state_q;
          end
        end else begin
          pop_s = 1'b0;
        end
      end
      L_FILL: begin
        if (out_free_s) begin
          cmd_d       = NOP_BYTE;
          cmd_valid_d = 1'b1;
          cnt_d       = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_d = L_OPS2; cnt_d = 3'd2;
          end else begin
            state_d = L_FILL;
          end
        end else begin
          state_d = L_FILL;
        end
      end
      L_WAIT: begin
        if (bus.ccu_ready) state_d = IDLE;
        else               state_d = L_WAIT;
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO storage; contents need no reset because the pointers are flushed
  always_ff @(posedge clk) begin
    if (push_s) mem_q[wr_ptr_q] <= bus.host_data;
  end

  // State, output and FIFO pointer registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      cmd_q       <= NOP_BYTE;
      cmd_valid_q <= 1'b0;
      err_q       <= 1'b0;
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      level_q     <= {(AW+1){1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      err_q       <= err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
    end
  end

`ifdef CMD_FEEDER_ERRCNT_EN
  // Saturating count of dropped unknown opcodes
  always_ff @(posedge clk) begin
    if (!rst_n) err_cnt_q <= 8'h00;
    else        err_cnt_q <= err_cnt_d;
  end
  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'h00;
`endif
endmodule

// File: tb/tb_cmd_feeder.sv
// Scoreboard bench for cmd_feeder: a command-level model queues expected cmd bytes,
// a monitor checks every consumed byte, with directed scenarios followed by random traffic.
module tb_cmd_feeder;
  localparam int DEPTH = 16;
  localparam int LFILL = 5;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   busy, err;
  logic [7:0]             err_cnt;
  logic [$clog2(DEPTH):0] fifo_level;

  cmd_feeder_if bus();

  cmd_feeder #(.DEPTH(DEPTH), .NOP_BYTE(8'h00), .LFILL(LFILL)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .err(err),
    .err_cnt(err_cnt), .fifo_level(fifo_level));

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         n_unknown = 0;
  int         ccu_mode = 0;   // 0 hold low, 1 hold high, 2 random
  logic [7:0] exp_q[$];
  logic [7:0] mon_e;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: expand one host command into the byte stream the CCU must see
  task automatic model(input logic [7:0] op, input logic [7:0] ops[7]);
    if (op == 8'd80) begin
      exp_q.push_back(op);
      for (int i = 0; i < 3; i++) exp_q.push_back(ops[i]);
    end else if (op == 8'd76) begin
      exp_q.push_back(op);
      for (int i = 0; i < 5; i++) exp_q.push_back(ops[i]);
      repeat (LFILL) exp_q.push_back(8'h00);
      exp_q.push_back(ops[5]);
      exp_q.push_back(ops[6]);
    end else begin
      n_unknown++;
    end
  endtask

  function automatic int exp_err_cnt();
`ifdef CMD_FEEDER_ERRCNT_EN
    return (n_unknown > 255) ? 255 : n_unknown;
`else
    return 0;
`endif
  endfunction

  task automatic push(input logic [7:0] b);
    int n = 0;
    bus.host_data  = b;
    bus.host_valid = 1'b1;
    while (!bus.host_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("push_accept", int'(bus.host_ready), 1);
    @(negedge clk);
    bus.host_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [7:0] op, input logic [7:0] ops[7], input int gap_max);
    int n;
    n = (op == 8'd80) ? 3 : ((op == 8'd76) ? 7 : 0);
    model(op, ops);
    push(op);
    repeat ($urandom_range(gap_max, 0)) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      push(ops[i]);
      repeat ($urandom_range(gap_max, 0)) @(negedge clk);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", int'(exp_q.size() == 0 && !busy), 1);
  endtask

  // CCU-side ready driver, updated just after each active edge
  initial begin
    bus.ccu_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ccu_mode)
        0:       bus.ccu_ready = 1'b0;
        1:       bus.ccu_ready = 1'b1;
        default: bus.ccu_ready = ($urandom_range(9, 0) < 7);
      endcase
    end
  end

  // Monitor: every byte the CCU takes is checked against the scoreboard head
  always @(negedge clk) begin
    if (rst_n && bus.cmd_valid && bus.ccu_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_cmd actual=%02h required=none", bus.cmd);
      end else begin
        mon_e = exp_q.pop_front();
        chk("cmd_byte", int'(bus.cmd), int'(mon_e));
      end
    end else if (rst_n && !bus.cmd_valid) begin
      chk("idle_cmd_nop", int'(bus.cmd), 0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog_timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ops[7];
    logic [7:0] strm[$];
    logic [7:0] op;
    int         idx, r;

    bus.host_valid = 1'b0;
    bus.host_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_host_ready_low", int'(bus.host_ready), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset with FIFO half full flushes everything
    for (int i = 0; i < DEPTH/2; i++) push(8'(8'h50 + i));
    chk("half_level", int'(fifo_level), DEPTH/2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_host_ready_in_rst", int'(bus.host_ready), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_level", int'(fifo_level), 0);
    chk("rst_cmd_valid", int'(bus.cmd_valid), 0);
    chk("rst_cmd", int'(bus.cmd), 0);
    chk("rst_host_ready", int'(bus.host_ready), 1);
    chk("rst_err", int'(err), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    chk("rst_busy", int'(busy), 0);

    // Point command with latency check
    ccu_mode = 1;
    repeat (2) @(negedge clk);
    ops = '{8'h0A, 8'h14, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00};
    model(8'h50, ops);
    push(8'h50);
    chk("lat_not_yet", int'(bus.cmd_valid), 0);
    push(8'h0A);
    chk("lat_opcode_out", int'(bus.cmd), 8'h50);
    chk("lat_opcode_valid", int'(bus.cmd_valid), 1);
    push(8'h14);
    push(8'h07);
    wait_drain();
    chk("point_busy_idle", int'(busy), 0);

    // Line command followed by a point held off by ccu_ready
    ops = '{8'h02, 8'h03, 8'h40, 8'h30, 8'h05, 8'h02, 8'h03};
    model(8'h4C, ops);
    push(8'h4C);
    for (int i = 0; i < 7; i++) push(ops[i]);
    ops = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00};
    model(8'h50, ops);
    push(8'h50);
    for (int i = 0; i < 3; i++) push(ops[i]);
    idx = 0;
    while (exp_q.size() > 4 && idx < 500) begin
      @(posedge clk);
      idx++;
    end
    ccu_mode = 0;
    repeat (20) @(negedge clk);
    chk("hold_level", int'(fifo_level), 4);
    chk("hold_busy", int'(busy), 1);
    ccu_mode = 1;
    wait_drain();

    // Host gap after the opcode, operand equal to the L opcode
    ops = '{8'h4C, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00};
    model(8'h50, ops);
    push(8'h50);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i >= 3) chk("gap_cmd_valid", int'(bus.cmd_valid), 0);
    end
    for (int i = 0; i < 3; i++) push(ops[i]);
    wait_drain();
    chk("gap_err", int'(err), 0);

    // Overfill with CCU stalled
    ccu_mode = 0;
    repeat (2) @(negedge clk);
    for (int c = 0; c < DEPTH/4; c++) begin
      ops = '{8'($urandom), 8'($urandom), 8'($urandom), 8'h00, 8'h00, 8'h00, 8'h00};
      model(8'h50, ops);
      strm.push_back(8'h50);
      for (int i = 0; i < 3; i++) strm.push_back(ops[i]);
    end
    strm.push_back(8'h50);
    strm.push_back(8'h5A);
    idx = 0;
    for (int t = 0; t < DEPTH + 6 && idx < DEPTH + 2; t++) begin
      bus.host_valid = 1'b1;
      bus.host_data  = strm[idx];
      if (bus.host_ready) idx++;
      @(negedge clk);
    end
    bus.host_valid = 1'b0;
    chk("full_accepted", idx, DEPTH);
    chk("full_level", int'(fifo_level), DEPTH);
    chk("full_host_ready", int'(bus.host_ready), 0);
    ccu_mode = 2;
    wait_drain();

    // Unknown opcode dropped, then a normal point
    ccu_mode = 1;
    ops = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00};
    model(8'h41, ops);
    push(8'h41);
    run_cmd(8'h50, ops, 0);
    wait_drain();
    chk("unk_err", int'(err), 1);
    chk("unk_err_cnt", int'(err_cnt), exp_err_cnt());

    // Random traffic
    ccu_mode = 2;
    for (int c = 0; c < 60; c++) begin
      r = $urandom_range(9, 0);
      if (r < 4)      op = 8'd80;
      else if (r < 7) op = 8'd76;
      else begin
        op = 8'($urandom);
        while (op == 8'd80 || op == 8'd76) op = 8'($urandom);
      end
      for (int i = 0; i < 7; i++) begin
        r = $urandom_range(7, 0);
        ops[i] = (r == 0) ? 8'd76 : ((r == 1) ? 8'd80 : 8'($urandom));
      end
      run_cmd(op, ops, 3);
    end
    wait_drain();
    chk("final_err", int'(err), 1);
    chk("final_err_cnt", int'(err_cnt), exp_err_cnt());
    chk("final_level", int'(fifo_level), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
